ee354_calc_controller: RTL and testbench



---
 rtl/ee354_calc_controller_if.sv | 28 ++
 rtl/ee354_calc_controller.sv | 114 +++++++++++
 tb/tb_ee354_calc_controller.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/ee354_calc_controller_if.sv
// Switch/button inputs and displayed results of the calculator controller.
// The master (top level or bench) drives Confirm/Ack/In; the controller drives the rest.
interface ee354_calc_controller_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic                 Confirm;
  logic                 Ack;
  logic [15:0]          In;
  logic [WIDTH-1:0]     A;
  logic [WIDTH-1:0]     B;
  logic [1:0]           Op;
  logic [2*WIDTH-1:0]   Result;
  logic [WIDTH-1:0]     Remainder;
  logic                 Neg;
  logic                 Done;
  logic                 Err;
  logic [9:0]           State;

  modport master (
    output Confirm, Ack, In,
    input  A, B, Op, Result, Remainder, Neg, Done, Err, State
  );

  modport slave (
    input  Confirm, Ack, In,
    output A, B, Op, Result, Remainder, Neg, Done, Err, State
  );
endinterface

// File: rtl/ee354_calc_controller.sv
// Calculator control unit: sequences operand/opcode entry and steps add, sub,
// shift-add multiply and repeated-subtraction divide.
module ee354_calc_controller #(
  parameter int unsigned WIDTH = 8
) (
  input logic                     Clk,
  input logic                     Reset,
  ee354_calc_controller_if.slave  bus
);
  localparam int unsigned RW   = 2 * WIDTH;
  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [9:0] {
    QI     = 10'b1000000000,
    QGetA  = 10'b0100000000,
    QGetB  = 10'b0010000000,
    QGetOp = 10'b0001000000,
    QAdd   = 10'b0000100000,
    QSub   = 10'b0000010000,
    QMul   = 10'b0000001000,
    QDiv   = 10'b0000000100,
    QErr   = 10'b0000000010,
    QDone  = 10'b0000000001
  } state_e;

  state_e            state_q;
  logic [WIDTH-1:0]  a_q, b_q, rem_q;
  logic [1:0]        op_q;
  logic [RW-1:0]     result_q;
  logic              neg_q;
  logic [CntW-1:0]   cnt_q;

  logic [RW-1:0]     a_ext, b_ext;
  assign a_ext = {{WIDTH{1'b0}}, a_q};
  assign b_ext = {{WIDTH{1'b0}}, b_q};

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= QI;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      result_q <= '0;
      rem_q    <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      unique case (state_q)
        QI: if (bus.Confirm) state_q <= QGetA;
        QGetA: if (bus.Confirm) begin
          a_q     <= bus.In[WIDTH-1:0];
          state_q <= QGetB;
        end
        QGetB: if (bus.Confirm) begin
          b_q     <= bus.In[WIDTH-1:0];
          state_q <= QGetOp;
        end
        QGetOp: if (bus.Confirm) begin
          op_q     <= bus.In[1:0];
          result_q <= '0;
          neg_q    <= 1'b0;
          cnt_q    <= '0;
          // Divide-by-zero goes to QErr, which must show a zero remainder.
          rem_q    <= (bus.In[1:0] == 2'b11 && b_q != '0) ? a_q : '0;
          unique case (bus.In[1:0])
            2'b00:   state_q <= QAdd;
            2'b01:   state_q <= QSub;
            2'b10:   state_q <= QMul;
            default: state_q <= (b_q != '0) ? QDiv : QErr;
          endcase
        end
        QAdd: begin
          result_q <= a_ext + b_ext;
          state_q  <= QDone;
        end
        QSub: begin
          if (a_q >= b_q) begin
            result_q <= a_ext - b_ext;
            neg_q    <= 1'b0;
          end else begin
            result_q <= b_ext - a_ext;
            neg_q    <= 1'b1;
          end
          state_q <= QDone;
        end
        QMul: begin
          if (b_q[cnt_q]) result_q <= result_q + (a_ext << cnt_q);
          cnt_q <= cnt_q + CntW'(1);
          if (cnt_q == CntW'(WIDTH - 1)) state_q <= QDone;
        end
        QDiv: begin
          if (rem_q >= b_q) begin
            rem_q    <= rem_q - b_q;
            result_q <= result_q + RW'(1);
          end else begin
            state_q <= QDone;
          end
        end
        QDone, QErr: if (bus.Ack) state_q <= QI;
        default: state_q <= QI;
      endcase
    end
  end

  assign bus.A         = a_q;
  assign bus.B         = b_q;
  assign bus.Op        = op_q;
  assign bus.Result    = result_q;
  assign bus.Remainder = rem_q;
  assign bus.Neg       = neg_q;
  assign bus.State     = state_q;
  assign bus.Done      = (state_q == QDone);
  assign bus.Err       = (state_q == QErr);
endmodule

// File: tb/tb_ee354_calc_controller.sv
// Directed bench for ee354_calc_controller: WIDTH=8 instance for the main
// sequences plus a WIDTH=4 instance for the narrow multiply.
module tb_ee354_calc_controller;
  localparam logic [9:0] SI    = 10'b1000000000;
  localparam logic [9:0] SGetA = 10'b0100000000;
  localparam logic [9:0] SAdd  = 10'b0000100000;
  localparam logic [9:0] SSub  = 10'b0000010000;
  localparam logic [9:0] SMul  = 10'b0000001000;
  localparam logic [9:0] SDiv  = 10'b0000000100;
  localparam logic [9:0] SErr  = 10'b0000000010;
  localparam logic [9:0] SDone = 10'b0000000001;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  int   cyc;

  ee354_calc_controller_if #(.WIDTH(8)) bus  ();
  ee354_calc_controller_if #(.WIDTH(4)) bus4 ();

  ee354_calc_controller #(.WIDTH(8)) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus.slave)
  );

  ee354_calc_controller #(.WIDTH(4)) dut4 (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus4.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs set afterwards are sampled at the next edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic confirm(input logic [15:0] val);
    bus.In      = val;
    bus.Confirm = 1'b1;
    step();
    bus.Confirm = 1'b0;
  endtask

  task automatic ack();
    bus.Ack = 1'b1;
    step();
    bus.Ack = 1'b0;
  endtask

  task automatic load(input logic [15:0] a, input logic [15:0] b, input logic [15:0] op);
    confirm(16'h0000);
    confirm(a);
    confirm(b);
    confirm(op);
  endtask

  initial begin
    n_tests      = 0;
    n_fail       = 0;
    rst          = 1'b1;
    bus.Confirm  = 1'b0;
    bus.Ack      = 1'b0;
    bus.In       = '0;
    bus4.Confirm = 1'b0;
    bus4.Ack     = 1'b0;
    bus4.In      = '0;
    step();
    step();
    check("rst_state", bus.State, SI);
    check("rst_result", bus.Result, 0);
    check("rst_a", bus.A, 0);
    rst = 1'b0;

    // 1: add with carry out, upper switch bits must be ignored
    load(16'hAAFF, 16'hFF01, 16'hFFFC);
    check("add_state", bus.State, SAdd);
    check("add_op", bus.Op, 2'b00);
    step();
    check("add_done_state", bus.State, SDone);
    check("add_result", bus.Result, 16'h0100);
    check("add_neg", bus.Neg, 0);
    check("add_rem", bus.Remainder, 0);
    check("add_done", bus.Done, 1);
    step();
    check("add_hold", bus.Result, 16'h0100);

    // 2: negative subtract, Ack outside QDone/QErr ignored
    ack();
    check("ack_to_qi", bus.State, SI);
    load(16'h0003, 16'h000A, 16'h0001);
    check("sub_state", bus.State, SSub);
    step();
    check("sub_result", bus.Result, 16'h0007);
    check("sub_neg", bus.Neg, 1);
    ack();
    confirm(16'h0000);
    check("geta_state", bus.State, SGetA);
    ack();
    check("geta_ack_ignored", bus.State, SGetA);
    rst = 1'b1;
    step();
    rst = 1'b0;

    // 3: 8-cycle multiply with stray Confirm pulses
    load(16'h00FF, 16'h00FF, 16'h0002);
    cyc = 0;
    while (bus.State == SMul && cyc < 40) begin
      bus.Confirm = (cyc == 2 || cyc == 5);
      bus.In      = 16'h0000;
      step();
      cyc++;
    end
    bus.Confirm = 1'b0;
    check("mul_cycles", cyc, 8);
    check("mul_state", bus.State, SDone);
    check("mul_result", bus.Result, 16'hFE01);
    check("mul_a_kept", bus.A, 8'hFF);
    check("mul_b_kept", bus.B, 8'hFF);
    ack();

    // 4: divide 100/7, then divide by zero
    load(16'h0064, 16'h0007, 16'h0003);
    check("div_rem_init", bus.Remainder, 8'h64);
    cyc = 0;
    while (bus.State == SDiv && cyc < 400) begin
      step();
      cyc++;
    end
    check("div_cycles", cyc, 15);
    check("div_result", bus.Result, 16'h000E);
    check("div_rem", bus.Remainder, 8'h02);
    check("div_done", bus.Done, 1);
    ack();
    load(16'h0005, 16'h0000, 16'h0003);
    check("err_state", bus.State, SErr);
    check("err_flag", bus.Err, 1);
    check("err_result", bus.Result, 0);
    check("err_rem", bus.Remainder, 0);
    ack();
    check("err_ack", bus.State, SI);

    // 5: reset on the 50th QDiv cycle, then a fresh add
    load(16'h00FF, 16'h0001, 16'h0003);
    for (int i = 0; i < 49; i++) step();
    check("div_mid_state", bus.State, SDiv);
    check("div_mid_result", bus.Result, 49);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_state", bus.State, SI);
    check("midrst_outs", {bus.A, bus.B, bus.Op, bus.Neg, bus.Done, bus.Err}, 0);
    check("midrst_result", bus.Result, 0);
    check("midrst_rem", bus.Remainder, 0);
    load(16'h0012, 16'h0034, 16'h0000);
    step();
    check("fresh_add", bus.Result, 16'h0046);

    // 6: Confirm+Ack together in QDone -> QI only
    bus.In      = 16'h0055;
    bus.Confirm = 1'b1;
    bus.Ack     = 1'b1;
    step();
    bus.Confirm = 1'b0;
    bus.Ack     = 1'b0;
    check("both_state", bus.State, SI);
    step();
    check("both_no_advance", bus.State, SI);
    check("both_a_kept", bus.A, 8'h12);

    // WIDTH=4 multiply 15*15
    for (int i = 0; i < 4; i++) begin
      bus4.In      = (i == 3) ? 16'h0002 : 16'h000F;
      bus4.Confirm = 1'b1;
      step();
    end
    bus4.Confirm = 1'b0;
    check("w4_mul_state", bus4.State, SMul);
    cyc = 0;
    while (bus4.State == SMul && cyc < 40) begin
      step();
      cyc++;
    end
    check("w4_mul_cycles", cyc, 4);
    check("w4_mul_result", bus4.Result, 8'hE1);
    check("w4_done", bus4.Done, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
